beep_note_player: RTL and testbench

- Parametrised successor to the single-tone beep generator.
- Accepts note requests (frequency in Hz, duration in ms) over a valid/ready handshake.
- Derives the half-period count with an on-chip sequential divider.
- Plays a square wave for exactly the requested duration, then inserts an optional inter-note gap. Feeds the board buzzer pin and is driven by the game-sound sequencer.

---
 rtl/beep_pkg.sv | 27 ++
 rtl/beep_seq_div.sv | 69 ++++++
 rtl/beep_note_player.sv | 149 ++++++++++++++
 tb/tb_beep_note_player.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and width helpers for the beep note player family.
// Shared by the top-level player and its sequential divider.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        PLAY,
        GAP
    } state_t;

    // Clock ticks per millisecond for a given system clock.
    function automatic int ms_ticks(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // ceil(log2(value)), never less than 1 so it can size a register.
    function automatic int clog2_w(input longint value);
        int w;
        w = 0;
        while ((longint'(1) << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/beep_seq_div.sv
// Restoring divider: quotient of the fixed dividend CLK_HZ/2 by divisor,
// one quotient bit per clock, done after exactly CNT_W cycles.
module beep_seq_div
    import beep_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ_W = 11,
    parameter int CNT_W  = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [FREQ_W-1:0] divisor,
    output logic              done,
    output logic [CNT_W-1:0]  quotient
);

    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ / 2);
    localparam int               IDX_W    = clog2_w(CNT_W);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CNT_W - 1);

    logic              running;
    logic [FREQ_W-1:0] dsor;
    logic [FREQ_W-1:0] rem;
    logic [FREQ_W-1:0] rem_next;
    logic [CNT_W-2:0]  q;
    logic [IDX_W-1:0]  idx;
    logic [FREQ_W:0]   trial;
    logic              fits;

    // Remainder stays below the divisor, so FREQ_W bits always suffice.
    always_comb begin
        trial    = {rem, DIVIDEND[idx]};
        fits     = (trial >= {1'b0, dsor});
        rem_next = fits ? FREQ_W'(trial - {1'b0, dsor}) : trial[FREQ_W-1:0];
    end

    // The last bit is presented combinationally so the caller can consume
    // the quotient on the same edge that finishes the division.
    assign done     = running && (idx == '0);
    assign quotient = {q, fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            dsor    <= '0;
            rem     <= '0;
            q       <= '0;
            idx     <= '0;
        end else if (clear) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            dsor    <= divisor;
            rem     <= '0;
            q       <= '0;
            idx     <= IDX_TOP;
        end else if (running) begin
            rem <= rem_next;
            q   <= quotient[CNT_W-2:0];
            idx <= idx - IDX_W'(1);
            if (idx == '0) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/beep_note_player.sv
// Note player: accepts (freq, duration) requests, divides down the clock to
// a half-period, plays a square wave for the duration, then a silent gap.
module beep_note_player
    import beep_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ_W = 11,
    parameter int DUR_W  = 12,
    parameter int CNT_W  = 26,
    parameter int GAP_MS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [FREQ_W-1:0] note_freq,
    input  logic [DUR_W-1:0]  note_dur_ms,
    input  logic              abort,
    output logic              melody,
    output logic              busy,
    output logic              note_done
);

    localparam int               MS_TICKS = ms_ticks(CLK_HZ);
    localparam int               PRE_W    = clog2_w(MS_TICKS);
    localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(MS_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_TOP  = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    state_t state;
    state_t state_next;

    logic              transfer;
    logic              div_done;
    logic [CNT_W-1:0]  div_q;
    logic [DUR_W-1:0]  dur_l;
    logic [CNT_W-1:0]  half_period;
    logic              silent;
    logic [CNT_W-1:0]  period_cnt;
    logic [PRE_W-1:0]  presc;
    logic [DUR_W-1:0]  ms_cnt;
    logic [DUR_W:0]    ms_cnt_inc;
    logic              ms_wrap;
    logic              per_wrap;
    logic              play_end;
    logic              gap_end;
    logic              stay;

    assign transfer = note_valid && note_ready;

    beep_seq_div #(
        .CLK_HZ (CLK_HZ),
        .FREQ_W (FREQ_W),
        .CNT_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (transfer && (note_freq != '0)),
        .clear    (abort && (state == DIV)),
        .divisor  (note_freq),
        .done     (div_done),
        .quotient (div_q)
    );

    // A ms ends when the prescaler wraps; the note ends on the wrap that
    // brings the ms count up to the latched duration.
    assign ms_wrap    = (presc == PRE_TOP);
    assign ms_cnt_inc = {1'b0, ms_cnt} + (DUR_W + 1)'(1);
    assign play_end   = (dur_l == '0) || (ms_wrap && (ms_cnt_inc == {1'b0, dur_l}));
    assign gap_end    = ms_wrap && (ms_cnt == GAP_TOP);
    assign per_wrap   = (period_cnt == half_period - CNT_W'(1));
    assign stay       = (state_next == state) && ((state == PLAY) || (state == GAP));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (transfer) state_next = (note_freq != '0) ? DIV : PLAY;
                DIV:  if (div_done) state_next = PLAY;
                PLAY: if (play_end) state_next = (GAP_MS > 0) ? GAP : IDLE;
                GAP:  if (gap_end)  state_next = IDLE;
                default:            state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        note_ready = (state == IDLE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_l       <= '0;
            half_period <= '0;
            silent      <= 1'b0;
            period_cnt  <= '0;
            presc       <= '0;
            ms_cnt      <= '0;
            melody      <= 1'b0;
            note_done   <= 1'b0;
        end else begin
            note_done <= (state == PLAY) && play_end && !abort;

            if (transfer) begin
                dur_l       <= note_dur_ms;
                silent      <= (note_freq == '0);
                half_period <= '0;
            end

            if ((state == DIV) && div_done && !abort) begin
                half_period <= div_q;
                silent      <= (div_q == '0);
            end

            // Counters restart on every state change so PLAY and GAP each
            // time themselves from their own entry edge.
            if (stay) begin
                presc      <= ms_wrap ? '0 : presc + PRE_W'(1);
                ms_cnt     <= ms_wrap ? ms_cnt + DUR_W'(1) : ms_cnt;
                period_cnt <= per_wrap ? '0 : period_cnt + CNT_W'(1);
            end else begin
                presc      <= '0;
                ms_cnt     <= '0;
                period_cnt <= '0;
            end

            if ((state == PLAY) && (state_next == PLAY)) begin
                melody <= melody ^ (per_wrap && !silent);
            end else begin
                melody <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beep_note_player.sv
// Self-checking bench for beep_note_player: two instances (8 kHz and 2 kHz
// clocks), a table of single notes plus abort, back-to-back and reset cases.
module tb_beep_note_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_a, abort_a, ready_a, melody_a, busy_a, done_a;
    logic [10:0] freq_a;
    logic [11:0] dur_a;
    logic        valid_b, abort_b, ready_b, melody_b, busy_b, done_b;
    logic [10:0] freq_b;
    logic [11:0] dur_b;

    int checks = 0;
    int errors = 0;

    beep_note_player #(
        .CLK_HZ (8000), .FREQ_W (11), .DUR_W (12), .CNT_W (12), .GAP_MS (1)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .note_valid (valid_a), .note_ready (ready_a),
        .note_freq (freq_a), .note_dur_ms (dur_a), .abort (abort_a),
        .melody (melody_a), .busy (busy_a), .note_done (done_a)
    );

    beep_note_player #(
        .CLK_HZ (2000), .FREQ_W (11), .DUR_W (12), .CNT_W (12), .GAP_MS (1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .note_valid (valid_b), .note_ready (ready_b),
        .note_freq (freq_b), .note_dur_ms (dur_b), .abort (abort_b),
        .melody (melody_b), .busy (busy_b), .note_done (done_b)
    );

    typedef struct {
        bit sel;       // 0: 8 kHz instance, 1: 2 kHz instance
        int freq;
        int dur;
        int hp;        // expected half period in cycles, 0 = silent
        int div_cyc;
        int play_cyc;
        int gap_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input int f, input int d);
        if (sel) begin
            valid_b = v; freq_b = 11'(f); dur_b = 12'(d);
        end else begin
            valid_a = v; freq_a = 11'(f); dur_a = 12'(d);
        end
    endtask

    task automatic get(input bit sel, output logic m, output logic d, output logic r, output logic b);
        m = sel ? melody_b : melody_a;
        d = sel ? done_b   : done_a;
        r = sel ? ready_b  : ready_a;
        b = sel ? busy_b   : busy_a;
    endtask

    task automatic run_note(input vec_t v, input int id);
        logic m, d, r, b;
        int   exp_m;
        get(v.sel, m, d, r, b);
        check($sformatf("v%0d ready_before", id), r, 1);
        drive(v.sel, 1'b1, v.freq, v.dur);
        tick();
        drive(v.sel, 1'b0, 0, 0);
        get(v.sel, m, d, r, b);
        check($sformatf("v%0d busy_after_xfer", id), b, 1);
        check($sformatf("v%0d ready_after_xfer", id), r, 0);
        for (int i = 1; i <= v.div_cyc; i++) begin
            tick();
            get(v.sel, m, d, r, b);
            check($sformatf("v%0d div%0d melody", id, i), m, 0);
            check($sformatf("v%0d div%0d done", id, i), d, 0);
        end
        for (int k = 1; k <= v.play_cyc; k++) begin
            tick();
            get(v.sel, m, d, r, b);
            exp_m = (k == v.play_cyc || v.hp == 0) ? 0 : (k / v.hp) % 2;
            check($sformatf("v%0d play%0d melody", id, k), m, exp_m);
            check($sformatf("v%0d play%0d done", id, k), d, (k == v.play_cyc) ? 1 : 0);
        end
        for (int g = 1; g <= v.gap_cyc; g++) begin
            tick();
            get(v.sel, m, d, r, b);
            check($sformatf("v%0d gap%0d melody", id, g), m, 0);
            check($sformatf("v%0d gap%0d ready", id, g), r, (g == v.gap_cyc) ? 1 : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dcount;

        // Hand-computed: Q = floor((CLK_HZ/2)/freq), play = dur*MS_TICKS.
        vecs[0] = '{0, 1000, 3, 4,    12, 24, 8};
        vecs[1] = '{0, 0,    2, 0,    0,  16, 8};
        vecs[2] = '{0, 2047, 1, 1,    12, 8,  8};
        vecs[3] = '{0, 1,    1, 4000, 12, 8,  8};
        vecs[4] = '{0, 1000, 0, 4,    12, 1,  8};
        vecs[5] = '{0, 700,  2, 5,    12, 16, 8};
        vecs[6] = '{1, 1500, 2, 0,    12, 4,  2};
        vecs[7] = '{1, 400,  3, 2,    12, 6,  2};

        rst_n = 1'b0;
        valid_a = 1'b0; abort_a = 1'b0; freq_a = '0; dur_a = '0;
        valid_b = 1'b0; abort_b = 1'b0; freq_b = '0; dur_b = '0;
        #2;
        check("reset ready", ready_a, 1);
        check("reset busy", busy_a, 0);
        check("reset melody", melody_a, 0);
        check("reset done", done_a, 0);
        check("reset ready_b", ready_b, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_note(vecs[i], i);
        end

        // Abort mid-PLAY: freq 500 -> half period 8, abort during PLAY cycle 10.
        drive(0, 1'b1, 500, 5);
        tick();
        drive(0, 1'b0, 0, 0);
        for (int i = 0; i < 12 + 9; i++) tick();
        check("abort pre melody", melody_a, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort ready", ready_a, 1);
        check("abort busy", busy_a, 0);
        check("abort melody", melody_a, 0);
        check("abort done", done_a, 0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_a === 1'b1) dcount++;
        end
        check("abort no late done", dcount, 0);

        // Abort during DIV, then the same note must still divide correctly.
        drive(0, 1'b1, 1000, 3);
        tick();
        drive(0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort div ready", ready_a, 1);
        run_note(vecs[0], 100);

        // Abort in IDLE does nothing; abort with a transfer loses to it.
        abort_a = 1'b1;
        tick();
        check("abort idle ready", ready_a, 1);
        check("abort idle busy", busy_a, 0);
        drive(0, 1'b1, 0, 1);
        tick();
        abort_a = 1'b0;
        drive(0, 1'b0, 0, 0);
        check("abort+xfer busy", busy_a, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("abort+xfer done%0d", k), done_a, (k == 8) ? 1 : 0);
        end
        for (int g = 1; g <= 8; g++) tick();
        check("abort+xfer ready", ready_a, 1);

        // Back-to-back with note_valid held: second note waits for IDLE.
        drive(0, 1'b1, 0, 1);
        tick();
        drive(0, 1'b1, 0, 2);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("b2b first done%0d", k), done_a, (k == 8) ? 1 : 0);
            check($sformatf("b2b first ready%0d", k), ready_a, (k == 16) ? 1 : 0);
        end
        tick();
        drive(0, 1'b0, 0, 0);
        check("b2b second busy", busy_a, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("b2b second done%0d", k), done_a, (k == 16) ? 1 : 0);
        end
        for (int g = 1; g <= 8; g++) tick();
        check("b2b final ready", ready_a, 1);

        // Asynchronous reset during DIV.
        drive(0, 1'b1, 1000, 3);
        tick();
        drive(0, 1'b0, 0, 0);
        tick(); tick(); tick();
        check("rst div busy before", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst div ready", ready_a, 1);
        check("rst div busy", busy_a, 0);
        check("rst div melody", melody_a, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst div ready after", ready_a, 1);

        // Asynchronous reset during PLAY while melody is high.
        drive(0, 1'b1, 1000, 3);
        tick();
        drive(0, 1'b0, 0, 0);
        for (int i = 0; i < 12 + 5; i++) tick();
        check("rst play melody before", melody_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst play melody", melody_a, 0);
        check("rst play ready", ready_a, 1);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst play ready after", ready_a, 1);
        check("rst play melody after", melody_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
